// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: FSM encoding, word size
// and the address legality check used by both requester ports.
package dmem_arbiter_pkg;

  // Arbiter ownership states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } arb_state_e;

  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned OFF_W      = $clog2(WORD_BYTES);

  // True when the byte address is word aligned and its word index lies in
  // 0..depth-1. Callers zero-extend their address to 64 bits.
  function automatic logic addr_ok(input logic [63:0] addr,
                                   input int unsigned depth);
    logic aligned;
    logic in_range;
    aligned  = (addr[OFF_W-1:0] == '0);
    in_range = ((addr >> OFF_W) < 64'(depth));
    return aligned && in_range;
  endfunction

endpackage

// File: rtl/dmem_addr_check.sv
// Per-requester address screen: flags misaligned or out-of-range byte
// addresses so the arbiter can keep them away from the memory.
module dmem_addr_check
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned AW    = 32,
  parameter int unsigned DEPTH = 64
) (
  input  logic [AW-1:0] addr_i,
  output logic          ok_o,
  output logic          err_o
);

  assign ok_o  = addr_ok(64'(addr_i), DEPTH);
  assign err_o = ~ok_o;

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing a single-port data memory between the CPU
// load/store path (requester 0) and the debug/boot loader (requester 1).
// One beat per cycle, bounded bursts under contention, read data returned
// exactly one cycle after the grant.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH     = 64,
  parameter int unsigned BURST_MAX = 4,
  parameter int unsigned AW        = 32
) (
  input  logic          clk,
  input  logic          rst,
  // requester 0
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [31:0]   wdata0,
  output logic          gnt0,
  output logic          rvalid0,
  output logic [31:0]   rdata0,
  output logic          err0,
  // requester 1
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [31:0]   wdata1,
  output logic          gnt1,
  output logic          rvalid1,
  output logic [31:0]   rdata1,
  output logic          err1,
  // memory
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_din,
  input  logic [31:0]   mem_dout
);

  localparam int unsigned CNT_W = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_MAX - 1);

  arb_state_e       state_q, state_d;
  logic             ptr_q, ptr_d;        // tie-break favourite: 0 or 1
  logic [CNT_W-1:0] cnt_q, cnt_d;        // beats granted in current burst - 1

  logic [AW-1:0]    mem_addr_q;
  logic [31:0]      mem_din_q;
  logic             rd_pend_q;           // a good read was issued last cycle
  logic             rd_sel_q;            // which requester that read belongs to
  logic [31:0]      rdata0_q, rdata1_q;

  logic             ok0, ok1, bad0, bad1;
  logic             any_gnt, sel_ok, sel_we, rd_issue;
  logic [AW-1:0]    sel_addr;
  logic [31:0]      sel_wdata;

  dmem_addr_check #(.AW(AW), .DEPTH(DEPTH)) u_chk0 (
    .addr_i (addr0),
    .ok_o   (ok0),
    .err_o  (bad0)
  );

  dmem_addr_check #(.AW(AW), .DEPTH(DEPTH)) u_chk1 (
    .addr_i (addr1),
    .ok_o   (ok1),
    .err_o  (bad1)
  );

  // Next-state, pointer, burst counter and combinational grants.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can
    // leave one unassigned and infer a latch.
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    if (!rst) begin
      unique case (state_q)
        ST_IDLE: begin
          cnt_d = '0;
          if (req0 && req1) begin
            if (ptr_q) begin
              gnt1    = 1'b1;
              state_d = ST_OWN1;
            end else begin
              gnt0    = 1'b1;
              state_d = ST_OWN0;
            end
          end else if (req0) begin
            gnt0    = 1'b1;
            state_d = ST_OWN0;
          end else if (req1) begin
            gnt1    = 1'b1;
            state_d = ST_OWN1;
          end
        end
        ST_OWN0: begin
          if (req0 && !(req1 && cnt_q == CNT_LAST)) begin
            gnt0 = 1'b1;
            if (cnt_q != CNT_LAST) cnt_d = cnt_q + CNT_W'(1);
          end else if (req1) begin
            // burst expired or owner dropped: hand over to requester 1
            gnt1    = 1'b1;
            state_d = ST_OWN1;
            ptr_d   = 1'b1;
            cnt_d   = '0;
          end else begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end
        end
        ST_OWN1: begin
          if (req1 && !(req0 && cnt_q == CNT_LAST)) begin
            gnt1 = 1'b1;
            if (cnt_q != CNT_LAST) cnt_d = cnt_q + CNT_W'(1);
          end else if (req0) begin
            gnt0    = 1'b1;
            state_d = ST_OWN0;
            ptr_d   = 1'b0;
            cnt_d   = '0;
          end else begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Memory-side mux: only a granted, legal access reaches the memory; the
  // address and write data otherwise hold their last values.
  assign any_gnt   = gnt0 | gnt1;
  assign sel_ok    = gnt1 ? ok1    : ok0;
  assign sel_we    = gnt1 ? we1    : we0;
  assign sel_addr  = gnt1 ? addr1  : addr0;
  assign sel_wdata = gnt1 ? wdata1 : wdata0;

  assign mem_we    = any_gnt & sel_ok & sel_we;
  assign rd_issue  = any_gnt & sel_ok & ~sel_we;
  assign mem_addr  = (any_gnt & sel_ok) ? sel_addr : mem_addr_q;
  assign mem_din   = mem_we ? sel_wdata : mem_din_q;

  assign err0      = gnt0 & bad0;
  assign err1      = gnt1 & bad1;

  // Read return: the memory output is valid the cycle after the grant and
  // is steered to the requester that issued the read; the other holds.
  assign rvalid0   = rd_pend_q & ~rd_sel_q & ~rst;
  assign rvalid1   = rd_pend_q &  rd_sel_q & ~rst;
  assign rdata0    = rvalid0 ? mem_dout : rdata0_q;
  assign rdata1    = rvalid1 ? mem_dout : rdata1_q;

  // State, pointer, counter and datapath holding registers.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of every other register.
    if (rst) begin
      state_q    <= ST_IDLE;
      ptr_q      <= 1'b0;
      cnt_q      <= '0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
      rd_pend_q  <= 1'b0;
      rd_sel_q   <= 1'b0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      mem_addr_q <= mem_addr;
      mem_din_q  <= mem_din;
      rd_pend_q  <= rd_issue;
      rd_sel_q   <= gnt1;
      rdata0_q   <= rdata0;
      rdata1_q   <= rdata1;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a behavioural
// read-first single-port memory (registered output, write commits at edge).
module tb_dmem_arbiter;

  localparam int unsigned AW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0, we0, req1, we1;
  logic [AW-1:0] addr0, addr1;
  logic [31:0]   wdata0, wdata1;
  logic          gnt0, rvalid0, err0, gnt1, rvalid1, err1;
  logic [31:0]   rdata0, rdata1;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_din, mem_dout;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] mem [0:63];

  dmem_arbiter #(.DEPTH(64), .BURST_MAX(4), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0), .err0(err0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1), .err1(err1),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;

  // Read-first memory: the sample taken at an edge sees the old word even
  // when a write to the same word commits at that edge.
  always @(posedge clk) begin
    mem_dout <= mem[mem_addr[7:2]];
    if (mem_we) mem[mem_addr[7:2]] = mem_din;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check32(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive0(input logic r, input logic w, input logic [31:0] a,
                        input logic [31:0] d);
    req0 = r; we0 = w; addr0 = a; wdata0 = d;
  endtask

  task automatic drive1(input logic r, input logic w, input logic [31:0] a,
                        input logic [31:0] d);
    req1 = r; we1 = w; addr1 = a; wdata1 = d;
  endtask

  logic [9:0] pat0;

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'hA000_0000 | i;
    rst = 1'b1;
    drive0(0, 0, 0, 0);
    drive1(0, 0, 0, 0);

    // ---- reset state
    tick(); tick(); settle();
    check1 ("rst_gnt0",    gnt0,    1'b0);
    check1 ("rst_gnt1",    gnt1,    1'b0);
    check1 ("rst_rvalid0", rvalid0, 1'b0);
    check1 ("rst_rvalid1", rvalid1, 1'b0);
    check1 ("rst_mem_we",  mem_we,  1'b0);
    check32("rst_mem_addr", mem_addr, 32'h0);
    check32("rst_mem_din",  mem_din,  32'h0);
    check32("rst_rdata0",   rdata0,   32'h0);
    check32("rst_rdata1",   rdata1,   32'h0);
    rst = 1'b0;

    // ---- reset during an active read
    drive0(1, 0, 32'h10, 0); settle();
    check1 ("rd10_gnt0", gnt0, 1'b1);
    check32("rd10_addr", mem_addr, 32'h10);
    check1 ("rd10_we",   mem_we, 1'b0);
    tick();
    rst = 1'b1;
    drive0(0, 0, 0, 0);
    drive1(1, 0, 32'h20, 0); settle();
    check1 ("inrst_rvalid0", rvalid0, 1'b0);
    check1 ("inrst_gnt1",    gnt1,    1'b0);
    check1 ("inrst_mem_we",  mem_we,  1'b0);
    tick();
    rst = 1'b0; settle();
    check1 ("postrst_rvalid0", rvalid0, 1'b0);
    check32("postrst_rdata0",  rdata0,  32'h0);
    check1 ("postrst_gnt1",    gnt1,    1'b1);
    check1 ("postrst_gnt0",    gnt0,    1'b0);
    check32("postrst_addr",    mem_addr, 32'h20);
    tick();
    drive1(0, 0, 0, 0); settle();
    check1 ("rd20_rvalid1", rvalid1, 1'b1);
    check32("rd20_rdata1",  rdata1,  32'hA000_0008);
    check1 ("rd20_rvalid0", rvalid0, 1'b0);

    // ---- single requester write then read
    tick();
    drive0(1, 1, 32'h8, 32'hDEAD_BEEF); settle();
    check1 ("wr8_gnt0", gnt0, 1'b1);
    check1 ("wr8_we",   mem_we, 1'b1);
    check32("wr8_addr", mem_addr, 32'h8);
    check32("wr8_din",  mem_din,  32'hDEAD_BEEF);
    check1 ("wr8_err0", err0, 1'b0);
    tick();
    drive0(1, 0, 32'h8, 0); settle();
    check1 ("rd8_gnt0",    gnt0,    1'b1);
    check1 ("rd8_we",      mem_we,  1'b0);
    check1 ("wr8_norvalid", rvalid0, 1'b0);
    tick();
    drive0(0, 0, 0, 0); settle();
    check1 ("rd8_rvalid0", rvalid0, 1'b1);
    check32("rd8_rdata0",  rdata0,  32'hDEAD_BEEF);
    check32("rd8_rdata1_hold", rdata1, 32'hA000_0008);

    // ---- contention: 4 beats each, never two grants at once
    tick();
    pat0 = 10'b11_0000_1111;
    drive0(1, 0, 32'h0, 0);
    drive1(1, 0, 32'h4, 0);
    for (int i = 0; i < 10; i++) begin
      settle();
      check1($sformatf("cont_gnt0_%0d", i), gnt0, pat0[i]);
      check1($sformatf("cont_gnt1_%0d", i), gnt1, ~pat0[i]);
      tick();
    end
    drive0(0, 0, 0, 0);
    drive1(0, 0, 0, 0); settle();
    check1("cont_end_gnt0", gnt0, 1'b0);
    check1("cont_end_gnt1", gnt1, 1'b0);

    // ---- simultaneous first request after reset, then a later tie
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive0(1, 0, 32'h0, 0);
    drive1(1, 0, 32'h4, 0); settle();
    check1("tie1_gnt0", gnt0, 1'b1);
    check1("tie1_gnt1", gnt1, 1'b0);
    tick();
    drive0(0, 0, 0, 0); settle();
    check1("hand_gnt1", gnt1, 1'b1);
    check1("hand_gnt0", gnt0, 1'b0);
    tick();
    drive1(0, 0, 0, 0); settle();
    check1("gap_gnt1", gnt1, 1'b0);
    tick();
    drive0(1, 0, 32'h0, 0);
    drive1(1, 0, 32'h4, 0); settle();
    check1("tie2_gnt1", gnt1, 1'b1);
    check1("tie2_gnt0", gnt0, 1'b0);
    tick();
    drive0(0, 0, 0, 0);
    drive1(0, 0, 0, 0); settle();

    // ---- bad addresses
    tick();
    drive1(1, 0, 32'h6, 0); settle();
    check1("mis_gnt1", gnt1, 1'b1);
    check1("mis_err1", err1, 1'b1);
    check1("mis_we",   mem_we, 1'b0);
    check1("mis_err0", err0, 1'b0);
    tick();
    drive1(0, 0, 0, 0); settle();
    check1("mis_norvalid1", rvalid1, 1'b0);
    check1("mis_err1_pulse", err1, 1'b0);
    tick();
    drive1(1, 1, 32'h100, 32'h1234_5678); settle();
    check1("oor_gnt1", gnt1, 1'b1);
    check1("oor_err1", err1, 1'b1);
    check1("oor_we",   mem_we, 1'b0);
    tick();
    drive1(1, 0, 32'hFC, 0); settle();
    check1("rdfc_gnt1", gnt1, 1'b1);
    check1("rdfc_err1", err1, 1'b0);
    tick();
    drive1(0, 0, 0, 0);
    drive0(1, 0, 32'h3, 0); settle();
    check1 ("rdfc_rvalid1", rvalid1, 1'b1);
    check32("rdfc_rdata1",  rdata1,  32'hA000_003F);
    check1 ("mis0_gnt0",    gnt0,    1'b1);
    check1 ("mis0_err0",    err0,    1'b1);
    tick();
    drive0(0, 0, 0, 0); settle();
    check1("mis0_norvalid0", rvalid0, 1'b0);
    check1("mis0_err0_pulse", err0, 1'b0);

    // ---- back-to-back reads
    tick();
    drive0(1, 0, 32'h0, 0); settle();
    check1("b2b_gnt0", gnt0, 1'b1);
    tick();
    drive0(1, 0, 32'h4, 0); settle();
    check1 ("b2b_rvalid_a", rvalid0, 1'b1);
    check32("b2b_rdata_a",  rdata0,  32'hA000_0000);
    tick();
    drive0(1, 0, 32'h8, 0); settle();
    check1 ("b2b_rvalid_b", rvalid0, 1'b1);
    check32("b2b_rdata_b",  rdata0,  32'hA000_0001);
    tick();
    drive0(0, 0, 0, 0); settle();
    check1 ("b2b_rvalid_c", rvalid0, 1'b1);
    check32("b2b_rdata_c",  rdata0,  32'hDEAD_BEEF);
    check32("b2b_rdata1",   rdata1,  32'hA000_003F);
    check1 ("b2b_rvalid1",  rvalid1, 1'b0);
    tick(); settle();
    check1 ("b2b_done_rvalid0", rvalid0, 1'b0);
    check32("b2b_hold_rdata0",  rdata0,  32'hDEAD_BEEF);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-port arbiter sharing the single-port data memory between requester 0 (CPU load/store path) and requester 1 (debug/boot loader).
- Sequences one word access per cycle to the memory.
- Grants in round-robin order with a bounded burst length.
- Returns read data one cycle after the grant, and rejects misaligned or out-of-range addresses before they reach the memory.

Parameters:
- DEPTH, 64, number of 32-bit words in the memory; valid word index 0..DEPTH-1.
- BURST_MAX, 4, maximum consecutive beats granted to one requester while the other is requesting.
- AW, 32, byte address width.

Ports:
- clk  in  1  clock
- rst  in  1  reset; one clock; reset is synchronous and active-high
- req0  in  1  requester 0 access request
- we0  in  1  requester 0 write enable (1=write, 0=read)
- addr0  in  AW  requester 0 byte address
- wdata0  in  32  requester 0 write data
- gnt0  out  1  requester 0 beat accepted this cycle
- rvalid0  out  1  requester 0 read data valid
- rdata0  out  32  requester 0 read data
- err0  out  1  requester 0 bad address, one-cycle pulse
- req1/we1/addr1/wdata1/gnt1/rvalid1/rdata1/err1  same widths and meanings, for requester 1
- mem_we  out  1  memory write enable
- mem_addr  out  AW  memory byte address (word aligned)
- mem_din  out  32  memory write data
- mem_dout  in  32  memory read data, registered in memory, valid one cycle after the address

Behaviour:
- Reset (rst=1 at a clk edge):
  - gnt0/1, rvalid0/1, err0/1, mem_we = 0; rdata0/1 = 0; mem_addr = 0; mem_din = 0.
  - State returns to IDLE, round-robin pointer = 0 (requester 0 favoured), burst counter = 0.
  - Reset mid-burst discards any pending rvalid; no write is issued in the reset cycle.
- Grant path:
  - Combinational from req/state; gnt asserts in the same cycle as req.
  - A requester holds req/we/addr/wdata stable until it sees gnt.
  - At most one gnt per cycle.
- Bad-address check, done before granting:
  - Misaligned: addr[1:0] != 0.
  - Out of range: addr[AW-1:2] >= DEPTH.
  - A bad access still receives gnt plus err for that cycle, but mem_we stays 0 and no rvalid follows.
- Good write: mem_we=1, mem_addr=addr, mem_din=wdata in the grant cycle; no read data is returned.
- Good read: mem_we=0, mem_addr=addr in the grant cycle; next cycle rvalid=1 and rdata=mem_dout for the granted requester only.
- rdata of the non-returning requester holds its last value.
- Read latency is exactly 1 cycle, so back-to-back reads return every cycle.
- FSM states:
  - IDLE:
    - No request: stay IDLE, mem_we=0.
    - One request: grant it, go to OWN0 or OWN1.
    - Both requesting: grant the pointer side.
  - OWNn:
    - reqn stays high and the other side is idle: keep granting, burst counter saturates.
    - reqn stays high, the other side requests, and burst counter < BURST_MAX-1: keep granting, counter++.
    - Counter reaches BURST_MAX-1 with the other side requesting: the next cycle grants the other side; pointer flips, counter clears, go to OWN(other).
    - reqn drops: the other side is granted if requesting, else go to IDLE; counter clears.
- Pointer update: after a grant switch, the pointer points away from the requester just served.
- Read followed by write to the same address in the next beat: the read returns old data.
- Write followed by read of the same address: the read returns new data; the memory commits the write before the read sample.
- With no grant, mem_addr holds its last value and mem_we=0.

Decomposition:
- Shared package holds:
  - the FSM state encoding (IDLE, OWN0, OWN1);
  - the WORD_BYTES=4 constant;
  - the address-check function (aligned and in range for a given DEPTH).
- One natural sub-module: dmem_addr_check (combinational, per requester: addr -> ok, err). Instantiate it twice.
- The arbiter FSM and read-return register stay in the top module.

Test Plan:
- Reset during active read: req0 read of 0x10 granted, then rst=1 next cycle -> rvalid0=0, state IDLE, all outputs 0, next req1 alone granted in the first cycle after reset.
- Single requester write then read:
  - req0 write 0x8 data 0xDEADBEEF -> gnt0=1, mem_we=1, mem_addr=0x8.
  - Next cycle req0 read 0x8 -> rvalid0=1, rdata0=0xDEADBEEF one cycle later.
- Contention with BURST_MAX=4: req0 and req1 held continuously from IDLE -> grant pattern 0,0,0,0,1,1,1,1,0..., never a gnt0 and gnt1 in the same cycle.
- Simultaneous first request after reset: both req asserted -> gnt0 first; after req0 drops, gnt1 next cycle; a later tie grants requester 1.
- Bad addresses:
  - req1 read 0x6 -> gnt1=1, err1=1, no rvalid1, mem_we=0.
  - req1 write 0x100 with DEPTH=64 -> err1=1, mem_we=0, memory unchanged (read 0x0FC still returns the prior value).
- Back-to-back reads: req0 reads 0x0, 0x4, 0x8 in consecutive cycles -> rvalid0 high for three consecutive cycles with the matching words, rdata1 unchanged.
